// File: rtl/combiner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : combiner_pkg
//  Purpose  : Shared types and widths for the combiner truth-table sweeper.
//             Holds the sweeper state encoding and the vector, truth-table
//             and counter widths used by combiner_sweeper.
//  Revision : 1.0  initial release
// ============================================================================
package combiner_pkg;

    localparam int VEC_W = 3;   // {a,b,c} vector index width
    localparam int TT_W  = 8;   // one truth-table bit per vector
    localparam int CNT_W = 4;   // settle counter and mismatch counter width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : combiner_pkg
`default_nettype wire

// File: rtl/combiner_sweeper.sv
`default_nettype none
// ============================================================================
//  Module   : combiner_sweeper
//  Purpose  : Walks the 3-input vector {a,b,c} through 0..7, holds each
//             vector for SETTLE_CYCLES cycles, samples the external
//             combiner output y, and builds the observed truth table while
//             counting mismatches against an expected table.
//  Ports    : clk, reset          clock / synchronous active-high reset
//             start, abort        sweep control
//             expected[7:0]       expected y per vector (sampled in SAMPLE)
//             y                   external combiner output
//             a, b, c             registered combiner inputs
//             busy, done, pass    status (done is a one-cycle pulse)
//             truth_table[7:0]    captured y per vector
//             mismatch_count[3:0] mismatches in current/last sweep
//  Revision : 1.0  initial release
// ============================================================================
module combiner_sweeper
    import combiner_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    input  logic            y,
    output logic            a,
    output logic            b,
    output logic            c,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TT_W-1:0] truth_table,
    output logic [CNT_W-1:0] mismatch_count
);

    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MM_MAX      = CNT_W'(TT_W);
    localparam logic [VEC_W-1:0] C_IDX_LAST    = VEC_W'(TT_W - 1);

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [TT_W-1:0]    tt_q,    tt_d;
    logic [CNT_W-1:0]   mm_q,    mm_d;
    logic [VEC_W-1:0]   vec_q,   vec_d;
    logic               pass_q,  pass_d;
    logic               done_q,  done_d;
    logic               busy_q,  busy_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort has priority over start when both arrive in IDLE
                if (start && !abort) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    mm_d    = '0;
                    pass_d  = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else if (cnt_q == C_SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                // an abort here discards the capture for this vector
                if (abort) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    tt_d[idx_q] = y;
                    if ((y != expected[idx_q]) && (mm_q != C_MM_MAX)) begin
                        mm_d = mm_q + 1'b1;
                    end
                    if (idx_q == C_IDX_LAST) begin
                        // done and pass become visible together in DONE
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (mm_d == '0);
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = '0;
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // outputs are registered from the next state so they line up with it
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
        vec_d  = busy_d ? idx_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            mm_q    <= '0;
            vec_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            vec_q   <= vec_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign a              = vec_q[2];
    assign b              = vec_q[1];
    assign c              = vec_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign truth_table    = tt_q;
    assign mismatch_count = mm_q;

endmodule : combiner_sweeper
`default_nettype wire
